// File: rtl/uart_command_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_command_pkg
//  Purpose  : Opcodes, response bytes and FSM state encoding for the UART
//             command controller.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_command_pkg;

    localparam logic [7:0] OP_WRITE       = 8'h01;
    localparam logic [7:0] OP_READ        = 8'h02;
    localparam logic [7:0] OP_PING        = 8'h03;
    localparam logic [7:0] RESP_PING      = 8'h55;
    localparam logic [7:0] RESP_WRITE_ACK = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_DATA       = 3'd2,
        ST_BUS_WRITE  = 3'd3,
        ST_BUS_READ   = 3'd4,
        ST_READ_WAIT  = 3'd5,
        ST_TX_RESP    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_command_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_command_controller_if
//  Purpose  : UART byte streams and 32-bit bus request/response signals of
//             the command controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_command_controller_if;

    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_write_data;
    logic        bus_write_req;
    logic        bus_read_req;
    logic        bus_ready;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;

    modport master (
        input  rx_data, rx_data_ready, tx_ready, bus_ready, bus_read_data, bus_read_data_valid,
        output tx_data, tx_valid, bus_addr, bus_write_data, bus_write_req, bus_read_req
    );

    modport slave (
        output rx_data, rx_data_ready, tx_ready, bus_ready, bus_read_data, bus_read_data_valid,
        input  tx_data, tx_valid, bus_addr, bus_write_data, bus_write_req, bus_read_req
    );

endinterface
`default_nettype wire

// File: rtl/uart_command_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_command_timeout
//  Purpose  : Loadable down-counter flagging an inter-byte gap of
//             TIMEOUT_CYCLES while enabled.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_command_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam int                c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= c_LOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A clear in the same cycle overrides expiry so an arriving byte always wins.
    assign o_expired = i_enable && !i_clear && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_command_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_command_controller
//  Purpose  : Turns UART bytes into bus write/read/ping commands and returns
//             responses through the UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_command_controller
    import uart_command_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    uart_command_controller_if.master  ctrl_if,
    output logic                       busy,
    output logic                       error
);

    state_t      r_state,    w_state_next;
    logic [7:0]  r_opcode,   w_opcode_next;
    logic [1:0]  r_index,    w_index_next;
    logic [31:0] r_addr,     w_addr_next;
    logic [31:0] r_wdata,    w_wdata_next;
    logic [31:0] r_tx_word,  w_tx_word_next;
    logic [1:0]  r_tx_last,  w_tx_last_next;
    logic [1:0]  r_tx_index, w_tx_index_next;
    logic        r_error,    w_error_next;
    logic        w_timeout_en;
    logic        w_expired;

    assign w_timeout_en = (r_state == ST_ADDR) || (r_state == ST_DATA);

    uart_command_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (ctrl_if.rx_data_ready),
        .i_enable  (w_timeout_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_opcode   <= '0;
            r_index    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_tx_word  <= '0;
            r_tx_last  <= '0;
            r_tx_index <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_opcode   <= w_opcode_next;
            r_index    <= w_index_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_tx_word  <= w_tx_word_next;
            r_tx_last  <= w_tx_last_next;
            r_tx_index <= w_tx_index_next;
            r_error    <= w_error_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_opcode_next   = r_opcode;
        w_index_next    = r_index;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_tx_word_next  = r_tx_word;
        w_tx_last_next  = r_tx_last;
        w_tx_index_next = r_tx_index;
        w_error_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ctrl_if.rx_data_ready) begin
                    w_opcode_next = ctrl_if.rx_data;
                    w_index_next  = 2'd0;
                    case (ctrl_if.rx_data)
                        OP_WRITE, OP_READ: w_state_next = ST_ADDR;
                        OP_PING: begin
                            w_tx_word_next  = {24'h0, RESP_PING};
                            w_tx_last_next  = 2'd0;
                            w_tx_index_next = 2'd0;
                            w_state_next    = ST_TX_RESP;
                        end
                        default: w_error_next = 1'b1;
                    endcase
                end
            end
            ST_ADDR: begin
                if (ctrl_if.rx_data_ready) begin
                    w_addr_next[{r_index, 3'b000} +: 8] = ctrl_if.rx_data;
                    w_index_next = r_index + 2'd1;
                    if (r_index == 2'd3) begin
                        w_state_next = (r_opcode == OP_WRITE) ? ST_DATA : ST_BUS_READ;
                    end
                end else if (w_expired) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (ctrl_if.rx_data_ready) begin
                    w_wdata_next[{r_index, 3'b000} +: 8] = ctrl_if.rx_data;
                    w_index_next = r_index + 2'd1;
                    if (r_index == 2'd3) begin
                        w_state_next = ST_BUS_WRITE;
                    end
                end else if (w_expired) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUS_WRITE: begin
                if (ctrl_if.bus_ready) begin
                    w_tx_word_next  = {24'h0, RESP_WRITE_ACK};
                    w_tx_last_next  = 2'd0;
                    w_tx_index_next = 2'd0;
                    w_state_next    = ST_TX_RESP;
                end
            end
            ST_BUS_READ: begin
                if (ctrl_if.bus_ready) begin
                    w_state_next = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (ctrl_if.bus_read_data_valid) begin
                    w_tx_word_next  = ctrl_if.bus_read_data;
                    w_tx_last_next  = 2'd3;
                    w_tx_index_next = 2'd0;
                    w_state_next    = ST_TX_RESP;
                end
            end
            ST_TX_RESP: begin
                if (ctrl_if.tx_ready) begin
                    if (r_tx_index == r_tx_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_tx_index_next = r_tx_index + 2'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Bytes arriving while the bus or transmitter is busy are dropped.
        if (ctrl_if.rx_data_ready &&
            ((r_state == ST_BUS_WRITE) || (r_state == ST_BUS_READ) ||
             (r_state == ST_READ_WAIT) || (r_state == ST_TX_RESP))) begin
            w_error_next = 1'b1;
        end
    end

    assign ctrl_if.tx_valid       = (r_state == ST_TX_RESP);
    assign ctrl_if.tx_data        = r_tx_word[{r_tx_index, 3'b000} +: 8];
    assign ctrl_if.bus_write_req  = (r_state == ST_BUS_WRITE);
    assign ctrl_if.bus_read_req   = (r_state == ST_BUS_READ);
    assign ctrl_if.bus_addr       = r_addr;
    assign ctrl_if.bus_write_data = r_wdata;
    assign busy                   = (r_state != ST_IDLE);
    assign error                  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_command_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_command_controller
//  Purpose  : Directed scoreboard bench for the UART command controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_command_controller;

    localparam int c_TO     = 16;
    localparam int c_EV_TX  = 0;
    localparam int c_EV_WR  = 1;
    localparam int c_EV_RD  = 2;
    localparam int c_EV_ERR = 3;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic error;

    uart_command_controller_if cif ();

    uart_command_controller #(
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl_if (cif.master),
        .busy    (busy),
        .error   (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    int          ready_delay = 0;
    int          read_delay  = 5;
    logic [31:0] rd_word = 32'h0;
    bit          tx_stall = 1'b0;

    task automatic push_ev(input int kind, input logic [63:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [63:0] act, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: got %h, nothing expected", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != act) begin
                errors++;
                $display("FAIL %s: got kind %0d value %h, expected kind %0d value %h",
                         name, kind, act, e.kind, e.val);
            end
        end
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        cif.rx_data       = b;
        cif.rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        cif.rx_data_ready = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: busy %b, pending events %0d, expected idle with 0 pending",
                     name, busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Bus slave: accepts after ready_delay cycles, returns read data read_delay cycles later.
    initial begin
        int wait_cnt;
        int rd_cnt;
        bit pending;
        wait_cnt = 0;
        rd_cnt   = 0;
        pending  = 1'b0;
        cif.bus_ready           = 1'b0;
        cif.bus_read_data_valid = 1'b0;
        cif.bus_read_data       = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cif.bus_ready           = 1'b0;
            cif.bus_read_data_valid = 1'b0;
            if (pending) begin
                rd_cnt++;
                if (rd_cnt >= read_delay) begin
                    cif.bus_read_data_valid = 1'b1;
                    cif.bus_read_data       = rd_word;
                    pending                 = 1'b0;
                end
            end
            if (reset_n && (cif.bus_write_req || cif.bus_read_req)) begin
                if (wait_cnt >= ready_delay) begin
                    cif.bus_ready = 1'b1;
                    wait_cnt      = 0;
                    if (cif.bus_read_req) begin
                        pending = 1'b1;
                        rd_cnt  = 0;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (!reset_n) pending = 1'b0;
        end
    end

    initial begin
        cif.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cif.tx_ready = tx_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: every observable transaction is matched against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (cif.bus_write_req && cif.bus_read_req) begin
                    errors++;
                    $display("FAIL both_req: got write %b read %b, expected not both high",
                             cif.bus_write_req, cif.bus_read_req);
                end
                if (cif.tx_valid && cif.tx_ready)
                    expect_ev(c_EV_TX, {56'h0, cif.tx_data}, "tx_byte");
                if (cif.bus_write_req && cif.bus_ready)
                    expect_ev(c_EV_WR, {cif.bus_addr, cif.bus_write_data}, "bus_write");
                if (cif.bus_read_req && cif.bus_ready)
                    expect_ev(c_EV_RD, {32'h0, cif.bus_addr}, "bus_read");
                if (error)
                    expect_ev(c_EV_ERR, 64'h0, "error_pulse");
            end
        end
    end

    initial begin
        cif.rx_data       = 8'h00;
        cif.rx_data_ready = 1'b0;
        reset_n           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_valid", {63'h0, cif.tx_valid}, 64'h0);
        check_eq("rst_tx_data", {56'h0, cif.tx_data}, 64'h0);
        check_eq("rst_wr_req", {63'h0, cif.bus_write_req}, 64'h0);
        check_eq("rst_rd_req", {63'h0, cif.bus_read_req}, 64'h0);
        check_eq("rst_addr", {32'h0, cif.bus_addr}, 64'h0);
        check_eq("rst_wdata", {32'h0, cif.bus_write_data}, 64'h0);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_error", {63'h0, error}, 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // PING
        push_ev(c_EV_TX, 64'h55);
        send_byte(8'h03);
        @(negedge clk);
        check_eq("ping_busy", {63'h0, busy}, 64'h1);
        wait_done("ping");

        // WRITE with 3 stall cycles on the bus
        ready_delay = 3;
        push_ev(c_EV_WR, {32'h8000_0010, 32'hDEAD_BEEF});
        push_ev(c_EV_TX, 64'hA5);
        send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        @(negedge clk);
        check_eq("write_req_latency", {63'h0, cif.bus_write_req}, 64'h1);
        wait_done("write");

        // READ with stalled transmitter
        ready_delay = 0;
        read_delay  = 5;
        rd_word     = 32'h1234_5678;
        tx_stall    = 1'b1;
        push_ev(c_EV_RD, 64'h4);
        push_ev(c_EV_TX, 64'h78);
        push_ev(c_EV_TX, 64'h56);
        push_ev(c_EV_TX, 64'h34);
        push_ev(c_EV_TX, 64'h12);
        send_byte(8'h02);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        check_eq("read_req_latency", {63'h0, cif.bus_read_req}, 64'h1);
        wait_done("read");
        tx_stall = 1'b0;

        // Bad opcode, then PING still answered
        push_ev(c_EV_ERR, 64'h0);
        send_byte(8'h7F);
        @(negedge clk);
        check_eq("badop_busy", {63'h0, busy}, 64'h0);
        wait_done("badop");
        push_ev(c_EV_TX, 64'h55);
        send_byte(8'h03);
        wait_done("ping_after_badop");

        // Timeout mid-write, then a full write
        push_ev(c_EV_ERR, 64'h0);
        send_byte(8'h01);
        send_byte(8'h10);
        wait_done("timeout");
        push_ev(c_EV_WR, {32'h0000_0020, 32'h0123_4567});
        push_ev(c_EV_TX, 64'hA5);
        send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h67); send_byte(8'h45); send_byte(8'h23); send_byte(8'h01);
        wait_done("write_after_timeout");

        // Overrun during READ_WAIT; read still completes
        read_delay = 10;
        rd_word    = 32'hA1B2_C3D4;
        push_ev(c_EV_RD, 64'h8);
        push_ev(c_EV_ERR, 64'h0);
        push_ev(c_EV_TX, 64'hD4);
        push_ev(c_EV_TX, 64'hC3);
        push_ev(c_EV_TX, 64'hB2);
        push_ev(c_EV_TX, 64'hA1);
        send_byte(8'h02);
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h99);
        wait_done("overrun");

        // Reset while the write request is held
        ready_delay = 50;
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        check_eq("held_wr_req", {63'h0, cif.bus_write_req}, 64'h1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_wr_req", {63'h0, cif.bus_write_req}, 64'h0);
        check_eq("mid_rst_tx_valid", {63'h0, cif.tx_valid}, 64'h0);
        check_eq("mid_rst_busy", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        ready_delay = 0;
        repeat (5) @(negedge clk);
        push_ev(c_EV_TX, 64'h55);
        send_byte(8'h03);
        wait_done("ping_after_reset");

        check_eq("queue_empty", {32'h0, exp_q.size()}, 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_command_controller.md
Name: uart_command_controller

Overview:
- Sequences the byte stream from the UART receiver (8-bit data plus 1-cycle data_ready pulse) into host commands: word write, word read, ping.
- Issues 32-bit memory-bus requests on behalf of the host and streams read responses back through the UART transmitter.
- Sits between uart_receiver/uart transmitter and the system bus; acts as the debug/program-load master.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one command before abort (>=2)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
rx_data  input  8  received byte, valid when rx_data_ready
rx_data_ready  input  1  single-cycle pulse: new byte
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data valid; held until accepted
tx_ready  input  1  transmitter can accept; transfer on tx_valid & tx_ready
bus_addr  output  32  word address (byte address, low 2 bits as received)
bus_write_data  output  32  write word
bus_write_req  output  1  write request; held until bus_ready
bus_read_req  output  1  read request; held until bus_ready
bus_ready  input  1  request accepted this cycle
bus_read_data  input  32  read word, valid with bus_read_data_valid
bus_read_data_valid  input  1  single-cycle pulse, arrives >=1 cycle after read accept
busy  output  1  high in any state except IDLE
error  output  1  single-cycle pulse: unknown opcode, timeout or overrun

Behaviour:
- Reset (clk edge with reset_n low): state IDLE; all outputs 0; byte counter, timeout counter, addr/data shift regs cleared. Reset mid-command abandons it silently; held requests drop immediately.
- Opcodes: 0x01 WRITE (4 addr bytes LE, 4 data bytes LE); 0x02 READ (4 addr bytes LE); 0x03 PING. Any other opcode: error pulse next cycle, stay IDLE.
- States: IDLE, ADDR, DATA, BUS_WRITE, BUS_READ, READ_WAIT, TX_RESP.
- IDLE: on rx_data_ready, latch opcode. 0x01/0x02 -> ADDR, byte_index=0. 0x03 -> TX_RESP with 1 byte 0x55.
- ADDR: each rx_data_ready writes byte into addr[8*i+:8]; after index 3: WRITE -> DATA (index=0), READ -> BUS_READ.
- DATA: same fill into write_data; after index 3 -> BUS_WRITE.
- BUS_WRITE: bus_write_req=1 from first cycle in state; when bus_ready high, deassert next cycle, emit ack byte 0xA5 via TX_RESP (1 byte).
- BUS_READ: bus_read_req=1 until bus_ready -> READ_WAIT. READ_WAIT: on bus_read_data_valid capture word -> TX_RESP, 4 bytes LE.
- TX_RESP: tx_valid=1 with current byte; on tx_valid & tx_ready advance; after last byte accepted -> IDLE next cycle. tx_data stable while tx_valid & !tx_ready.
- bus_write_req and bus_read_req never both high; bus_addr/bus_write_data stable while request held.
- Timeout: counter runs only in ADDR/DATA; clears on every rx_data_ready; reaching TIMEOUT_CYCLES -> error pulse, -> IDLE, partial command discarded. No timeout on bus or tx waits.
- Overrun: rx_data_ready in BUS_WRITE, BUS_READ, READ_WAIT or TX_RESP -> byte dropped, error pulse; sequence continues unaffected.
- rx_data_ready coincident with timeout expiry: byte wins (counter cleared, no error).
- Back-to-back commands: new opcode accepted the cycle after return to IDLE; no dead cycles required beyond that.
- Latency: last addr/data byte pulse -> bus request asserted 1 cycle later.

Decomposition:
- Package uart_command_pkg: opcode constants (OP_WRITE, OP_READ, OP_PING), response constants (RESP_PING 0x55, RESP_WRITE_ACK 0xA5), state enum.
- One sub-module natural: uart_command_timeout (loadable down-counter, clear/enable inputs, expired output).

Test Plan:
- PING: bytes 0x03 -> tx 0x55 once, no bus activity, busy low after accept.
- WRITE: 0x01,0x10,0x00,0x00,0x80,0xEF,0xBE,0xAD,0xDE -> one bus write addr 0x80000010 data 0xDEADBEEF held across 3 cycles of bus_ready=0; then tx 0xA5.
- READ: 0x02,0x04,0x00,0x00,0x00; bus returns 0x12345678 after 5 cycles -> tx bytes 0x78,0x56,0x34,0x12 in order with tx_ready stalled randomly.
- Bad opcode 0x7F -> error pulse, no bus/tx activity; following 0x03 still answered 0x55.
- Timeout: 0x01,0x10 then silence TIMEOUT_CYCLES (set 16) -> error pulse, IDLE; subsequent full WRITE executes correctly.
- Overrun + reset: byte sent during READ_WAIT -> error, read still completes; reset_n low during BUS_WRITE -> bus_write_req 0 next cycle, no tx.
